// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - byte-stream loader assembling two zero-padded 5x5 int8 matrices
module matrix_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_start,
    input  logic [2:0]   mat_size,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [199:0] matrix_a,
    output logic [199:0] matrix_b,
    output logic         matrix_valid,
    input  logic         matrix_ack,
    output logic         size_error
);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, READY} state_t;

    state_t      state, state_next;
    logic [2:0]  n_reg;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        size_ok;
    logic        xfer;
    logic        last_elem;
    logic [7:0]  bit_idx;

    assign size_ok   = (mat_size >= 3'd2) && (mat_size <= 3'd5);
    // in_ready is a registered copy of "state is LOAD_A/LOAD_B", so it gates transfers directly
    assign xfer      = in_valid && in_ready;
    assign last_elem = (row == n_reg - 3'd1) && (col == n_reg - 3'd1);
    assign bit_idx   = 8'(row) * 8'd40 + 8'(col) * 8'd8;

    always_comb begin
        state_next = state;
        if (load_start) begin
            state_next = size_ok ? LOAD_A : IDLE;
        end else begin
            case (state)
                LOAD_A:  if (xfer && last_elem) state_next = LOAD_B;
                LOAD_B:  if (xfer && last_elem) state_next = READY;
                READY:   if (matrix_ack) state_next = IDLE;
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            matrix_a     <= '0;
            matrix_b     <= '0;
            in_ready     <= 1'b0;
            matrix_valid <= 1'b0;
            size_error   <= 1'b0;
            row          <= '0;
            col          <= '0;
            n_reg        <= '0;
        end else begin
            state        <= state_next;
            in_ready     <= (state_next == LOAD_A) || (state_next == LOAD_B);
            matrix_valid <= (state_next == READY);
            if (load_start) begin
                if (size_ok) begin
                    matrix_a   <= '0;
                    matrix_b   <= '0;
                    n_reg      <= mat_size;
                    row        <= '0;
                    col        <= '0;
                    size_error <= 1'b0;
                end else begin
                    size_error <= 1'b1;
                end
            end else if (xfer) begin
                if (state == LOAD_A)
                    matrix_a[bit_idx +: 8] <= in_data;
                else
                    matrix_b[bit_idx +: 8] <= in_data;
                if (last_elem) begin
                    row <= '0;
                    col <= '0;
                end else if (col < n_reg - 3'd1) begin
                    col <= col + 3'd1;
                end else begin
                    col <= '0;
                    row <= row + 3'd1;
                end
            end
        end
    end

endmodule
